// File: rtl/match_extractor.sv
// Turns each 256-bit shift-or filter state word into a stream of packet-relative
// candidate byte positions, one record per cycle, behind a small burst FIFO.
module match_extractor #(
    parameter int FIFO_DEPTH = 8,
    parameter int POS_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [255:0]     in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [POS_W-1:0] out_pos,
    output logic             out_last,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 32 + POS_W + 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    logic [31:0]      flags;
    logic             data_unused;
    logic [POS_W-1:0] run_base;
    logic [POS_W-1:0] beat_base;
    logic             enq_req;
    logic             push;
    logic             pop;
    logic             drop;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;

    logic             state;
    logic [31:0]      rem_flags;
    logic [POS_W-1:0] w_base;
    logic             w_last;
    logic [4:0]       k;
    logic             is_final;
    logic             xfer;

    // Only bit 7 of each byte carries the filter result.
    assign data_unused = ^in_data;

    always_comb begin
        for (int i = 0; i < 32; i++) flags[i] = ~in_data[8*i+7];
    end

    assign beat_base = in_sop ? '0 : run_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_base <= '0;
        else if (in_valid) run_base <= beat_base + POS_W'(32);
    end

    assign enq_req = in_valid & ((|flags) | in_eop);
    assign push    = enq_req & (~full | pop);
    assign drop    = enq_req & full & ~pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // NOTE: FIFO storage is deliberately not reset; the pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {flags, beat_base, in_eop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // NOTE: k gets a default before the loop so the priority encoder cannot infer a latch.
    always_comb begin
        k = '0;
        for (int i = 31; i >= 0; i--) begin
            if (rem_flags[i]) k = 5'(i);
        end
    end

    // An entry's final record is reached once at most one flag remains.
    assign is_final = ((rem_flags & (rem_flags - 32'd1)) == 32'd0);
    assign xfer     = (state == ST_SCAN) & out_ready;
    assign pop      = ~empty & ((state == ST_IDLE) | (xfer & is_final));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem_flags <= '0;
            w_base    <= '0;
            w_last    <= 1'b0;
        end else if (pop) begin
            state                         <= ST_SCAN;
            {rem_flags, w_base, w_last}   <= mem[rd_ptr[AW-1:0]];
        end else if (xfer) begin
            if (is_final) state <= ST_IDLE;
            rem_flags <= rem_flags & (rem_flags - 32'd1);
        end
    end

    assign out_valid = (state == ST_SCAN);
    assign out_hit   = |rem_flags;
    assign out_pos   = w_base + POS_W'(k);
    assign out_last  = w_last & is_final;

endmodule
